// File: rtl/define_state.sv
// ============================================================================
// Module : define_state (package)
// Brief  : Sequencer state encoding, SRAM grant codes and timeout defaults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package define_state;

  typedef enum logic [2:0] {
    S_SEQ_IDLE      = 3'd0,
    S_SEQ_UART_INIT = 3'd1,
    S_SEQ_UART_EN   = 3'd2,
    S_SEQ_UART_WAIT = 3'd3,
    S_SEQ_GUARD     = 3'd4,
    S_SEQ_M2        = 3'd5,
    S_SEQ_M1        = 3'd6,
    S_SEQ_DISPLAY   = 3'd7
  } seq_state_type;

  localparam logic [2:0] c_GRANT_IDLE = 3'd0;
  localparam logic [2:0] c_GRANT_UART = 3'd1;
  localparam logic [2:0] c_GRANT_M2   = 3'd2;
  localparam logic [2:0] c_GRANT_M1   = 3'd3;
  localparam logic [2:0] c_GRANT_VGA  = 3'd4;

  localparam logic [25:0] c_UART_TIMEOUT_DEFAULT = 26'd49999999;
  localparam logic [27:0] c_WDOG_CYCLES_DEFAULT  = 28'd200000000;

  // Guard cycles own nothing, so the bus parks with writes disabled.
  function automatic logic [2:0] grant_of(input seq_state_type state);
    logic [2:0] grant;
    case (state)
      S_SEQ_IDLE, S_SEQ_DISPLAY:                        grant = c_GRANT_VGA;
      S_SEQ_UART_INIT, S_SEQ_UART_EN, S_SEQ_UART_WAIT:  grant = c_GRANT_UART;
      S_SEQ_M2:                                         grant = c_GRANT_M2;
      S_SEQ_M1:                                         grant = c_GRANT_M1;
      default:                                          grant = c_GRANT_IDLE;
    endcase
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_timer.sv
// ============================================================================
// Module : seq_timer
// Brief  : Clearable up-counter with equality compare against a limit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_hit
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_hit = (r_count == i_limit);

endmodule

`default_nettype wire

// File: rtl/decode_sequencer.sv
// ============================================================================
// Module : decode_sequencer
// Brief  : Load/decode/display sequencer with SRAM ownership mux and watchdog.
//          Define SEQ_SIM_AUTOSTART_EN to launch M2 once after reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_sequencer
  import define_state::*;
#(
  parameter logic [25:0] UART_TIMEOUT = c_UART_TIMEOUT_DEFAULT,
  parameter logic [27:0] WDOG_CYCLES  = c_WDOG_CYCLES_DEFAULT
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        Start_req,
  input  logic [17:0] UART_SRAM_address,
  input  logic [15:0] UART_SRAM_write_data,
  input  logic        UART_SRAM_we_n,
  input  logic [17:0] M1_SRAM_address,
  input  logic [15:0] M1_SRAM_write_data,
  input  logic        M1_SRAM_we_n,
  input  logic        M1_done,
  input  logic [17:0] M2_SRAM_address,
  input  logic [15:0] M2_SRAM_write_data,
  input  logic        M2_SRAM_we_n,
  input  logic        M2_done,
  input  logic [17:0] VGA_SRAM_address,
  output logic        UART_rx_initialize,
  output logic        UART_rx_enable,
  output logic        M1_start,
  output logic        M2_start,
  output logic        VGA_enable,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [2:0]  Grant,
  output logic        Busy,
  output logic        Wdog_error
);

  seq_state_type r_state;
  seq_state_type w_state_next;
  seq_state_type r_guard_next;
  seq_state_type w_guard_next;
  logic [2:0]    r_grant;
  logic [17:0]   r_addr_hold;
  logic          r_wdog_err;
  logic          w_wdog_err_next;
  logic          w_wdog_fire;
  logic          w_uart_hit;
  logic          w_wdog_hit;
  logic          w_uart_clr;
  logic          w_wdog_run;
  logic          w_autostart;

`ifdef SEQ_SIM_AUTOSTART_EN
  logic r_autostart_pending;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_autostart_pending <= 1'b1;
    end else if (r_state == S_SEQ_IDLE) begin
      r_autostart_pending <= 1'b0;
    end
  end

  assign w_autostart = r_autostart_pending;
`else
  assign w_autostart = 1'b0;
`endif

  // A timeout with nothing loaded yet just restarts the idle window.
  assign w_uart_clr = (r_state != S_SEQ_UART_WAIT) || !UART_SRAM_we_n ||
                      (w_uart_hit && (UART_SRAM_address == '0));
  assign w_wdog_run = (r_state == S_SEQ_M1) || (r_state == S_SEQ_M2);

  seq_timer #(.WIDTH(26)) u_uart_timer (
    .clk     (Clock_50),
    .rst_n   (Resetn),
    .i_clr   (w_uart_clr),
    .i_en    (1'b1),
    .i_limit (UART_TIMEOUT),
    .o_hit   (w_uart_hit)
  );

  seq_timer #(.WIDTH(28)) u_wdog_timer (
    .clk     (Clock_50),
    .rst_n   (Resetn),
    .i_clr   (!w_wdog_run),
    .i_en    (1'b1),
    .i_limit (WDOG_CYCLES),
    .o_hit   (w_wdog_hit)
  );

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_SEQ_IDLE;
      r_guard_next <= S_SEQ_IDLE;
      r_grant      <= c_GRANT_VGA;
      r_wdog_err   <= 1'b0;
      r_addr_hold  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_guard_next <= w_guard_next;
      r_grant      <= grant_of(w_state_next);
      r_wdog_err   <= w_wdog_err_next;
      if (r_grant != c_GRANT_IDLE) begin
        r_addr_hold <= SRAM_address;
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_guard_next       = r_guard_next;
    w_wdog_err_next    = r_wdog_err;
    w_wdog_fire        = 1'b0;
    UART_rx_initialize = 1'b0;
    UART_rx_enable     = 1'b0;
    M1_start           = 1'b0;
    M2_start           = 1'b0;
    VGA_enable         = 1'b0;
    case (r_state)
      S_SEQ_IDLE: begin
        VGA_enable = 1'b1;
        if (w_autostart) begin
          w_state_next = S_SEQ_GUARD;
          w_guard_next = S_SEQ_M2;
        end else if (Start_req) begin
          w_state_next    = S_SEQ_UART_INIT;
          w_wdog_err_next = 1'b0;
        end
      end
      S_SEQ_UART_INIT: begin
        UART_rx_initialize = 1'b1;
        w_state_next       = S_SEQ_UART_EN;
      end
      S_SEQ_UART_EN: begin
        UART_rx_enable = 1'b1;
        w_state_next   = S_SEQ_UART_WAIT;
      end
      S_SEQ_UART_WAIT: begin
        if (w_uart_hit && (UART_SRAM_address != '0)) begin
          UART_rx_initialize = 1'b1;
          w_state_next       = S_SEQ_GUARD;
          w_guard_next       = S_SEQ_M2;
        end
      end
      S_SEQ_GUARD: begin
        w_state_next = r_guard_next;
      end
      S_SEQ_M2: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (M2_done) begin
          w_state_next = S_SEQ_GUARD;
          w_guard_next = S_SEQ_M1;
        end else if (w_wdog_hit) begin
          w_wdog_fire     = 1'b1;
          w_wdog_err_next = 1'b1;
          w_state_next    = S_SEQ_GUARD;
          w_guard_next    = S_SEQ_IDLE;
        end
        M2_start = !w_wdog_fire;
      end
      S_SEQ_M1: begin
        if (M1_done) begin
          w_state_next = S_SEQ_GUARD;
          w_guard_next = S_SEQ_DISPLAY;
        end else if (w_wdog_hit) begin
          w_wdog_fire     = 1'b1;
          w_wdog_err_next = 1'b1;
          w_state_next    = S_SEQ_GUARD;
          w_guard_next    = S_SEQ_IDLE;
        end
        M1_start = !w_wdog_fire;
      end
      S_SEQ_DISPLAY: begin
        VGA_enable   = 1'b1;
        w_state_next = S_SEQ_IDLE;
      end
      default: begin
        w_state_next = S_SEQ_IDLE;
      end
    endcase
  end

  always_comb begin
    SRAM_address    = r_addr_hold;
    SRAM_write_data = UART_SRAM_write_data;
    SRAM_we_n       = 1'b1;
    case (r_grant)
      c_GRANT_UART: begin
        SRAM_address = UART_SRAM_address;
        SRAM_we_n    = UART_SRAM_we_n;
      end
      c_GRANT_M2: begin
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_write_data;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      c_GRANT_M1: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      c_GRANT_VGA: begin
        SRAM_address = VGA_SRAM_address;
      end
      default: begin
      end
    endcase
  end

  assign Grant      = r_grant;
  assign Busy       = (r_state != S_SEQ_IDLE);
  assign Wdog_error = r_wdog_err || w_wdog_fire;

endmodule

`default_nettype wire

// File: tb/tb_decode_sequencer.sv
// ============================================================================
// Module : tb_decode_sequencer
// Brief  : Directed bench for decode_sequencer (UART_TIMEOUT=100, WDOG=50).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_sequencer;

  localparam logic [2:0] G_IDLE = 3'd0;
  localparam logic [2:0] G_UART = 3'd1;
  localparam logic [2:0] G_M2   = 3'd2;
  localparam logic [2:0] G_M1   = 3'd3;
  localparam logic [2:0] G_VGA  = 3'd4;

  logic        Clock_50 = 1'b0;
  logic        Resetn;
  logic        Start_req;
  logic [17:0] UART_SRAM_address;
  logic [15:0] UART_SRAM_write_data;
  logic        UART_SRAM_we_n;
  logic [17:0] M1_SRAM_address;
  logic [15:0] M1_SRAM_write_data;
  logic        M1_SRAM_we_n;
  logic        M1_done;
  logic [17:0] M2_SRAM_address;
  logic [15:0] M2_SRAM_write_data;
  logic        M2_SRAM_we_n;
  logic        M2_done;
  logic [17:0] VGA_SRAM_address;
  logic        UART_rx_initialize;
  logic        UART_rx_enable;
  logic        M1_start;
  logic        M2_start;
  logic        VGA_enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [2:0]  Grant;
  logic        Busy;
  logic        Wdog_error;

  always #10 Clock_50 = ~Clock_50;

  decode_sequencer #(
    .UART_TIMEOUT (26'd100),
    .WDOG_CYCLES  (28'd50)
  ) dut (
    .Clock_50             (Clock_50),
    .Resetn               (Resetn),
    .Start_req            (Start_req),
    .UART_SRAM_address    (UART_SRAM_address),
    .UART_SRAM_write_data (UART_SRAM_write_data),
    .UART_SRAM_we_n       (UART_SRAM_we_n),
    .M1_SRAM_address      (M1_SRAM_address),
    .M1_SRAM_write_data   (M1_SRAM_write_data),
    .M1_SRAM_we_n         (M1_SRAM_we_n),
    .M1_done              (M1_done),
    .M2_SRAM_address      (M2_SRAM_address),
    .M2_SRAM_write_data   (M2_SRAM_write_data),
    .M2_SRAM_we_n         (M2_SRAM_we_n),
    .M2_done              (M2_done),
    .VGA_SRAM_address     (VGA_SRAM_address),
    .UART_rx_initialize   (UART_rx_initialize),
    .UART_rx_enable       (UART_rx_enable),
    .M1_start             (M1_start),
    .M2_start             (M2_start),
    .VGA_enable           (VGA_enable),
    .SRAM_address         (SRAM_address),
    .SRAM_write_data      (SRAM_write_data),
    .SRAM_we_n            (SRAM_we_n),
    .Grant                (Grant),
    .Busy                 (Busy),
    .Wdog_error           (Wdog_error)
  );

  typedef struct {
    logic [17:0] own_addr;
    logic [15:0] own_data;
    logic        own_we_n;
    logic [17:0] vga_addr;
    logic [17:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_we_n;
  } mux_vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clock_50);
    #1;
  endtask

  // IDLE -> UART_INIT -> UART_EN -> UART_WAIT
  task automatic start_load();
    Start_req = 1'b1;
    step();
    Start_req = 1'b0;
    step();
    step();
  endtask

  // From UART_WAIT: one write, timeout, then M2 (done at once), arriving in M1.
  task automatic finish_load_to_m1();
    int cyc;
    UART_SRAM_address = 18'd5;
    UART_SRAM_we_n    = 1'b0;
    step();
    UART_SRAM_we_n    = 1'b1;
    cyc = 0;
    while (!UART_rx_initialize && cyc < 300) begin
      step();
      cyc++;
    end
    check("load_rx_init_seen", UART_rx_initialize, 1);
    step();
    step();
    M2_done = 1'b1;
    step();
    M2_done = 1'b0;
    step();
    check("load_in_m1_grant", Grant, G_M1);
  endtask

  initial begin
    mux_vec_t idle_tab[4];
    mux_vec_t m1_tab[4];
    int       cyc;
    int       bad;

    idle_tab[0] = '{18'h00011, 16'hA5A5, 1'b0, 18'h00100, 18'h00100, 16'hA5A5, 1'b1};
    idle_tab[1] = '{18'h3FFFF, 16'hFFFF, 1'b1, 18'h3FFFF, 18'h3FFFF, 16'hFFFF, 1'b1};
    idle_tab[2] = '{18'h00000, 16'h0000, 1'b0, 18'h00000, 18'h00000, 16'h0000, 1'b1};
    idle_tab[3] = '{18'h12345, 16'h1357, 1'b0, 18'h2ABCD, 18'h2ABCD, 16'h1357, 1'b1};
    m1_tab[0]   = '{18'h2AAAA, 16'h5555, 1'b0, 18'h00007, 18'h2AAAA, 16'h5555, 1'b0};
    m1_tab[1]   = '{18'h15555, 16'hAAAA, 1'b1, 18'h00007, 18'h15555, 16'hAAAA, 1'b1};
    m1_tab[2]   = '{18'h3FFFF, 16'hFFFF, 1'b0, 18'h00007, 18'h3FFFF, 16'hFFFF, 1'b0};
    m1_tab[3]   = '{18'h00000, 16'h0000, 1'b1, 18'h00007, 18'h00000, 16'h0000, 1'b1};

    Resetn = 1'b0;  Start_req = 1'b0;
    UART_SRAM_address = '0; UART_SRAM_write_data = '0; UART_SRAM_we_n = 1'b1;
    M1_SRAM_address = '0; M1_SRAM_write_data = '0; M1_SRAM_we_n = 1'b1; M1_done = 1'b0;
    M2_SRAM_address = '0; M2_SRAM_write_data = '0; M2_SRAM_we_n = 1'b1; M2_done = 1'b0;
    VGA_SRAM_address = '0;

    repeat (3) step();
    check("rst_grant", Grant, G_VGA);
    check("rst_vga_enable", VGA_enable, 1);
    check("rst_busy", Busy, 0);
    check("rst_we_n", SRAM_we_n, 1);
    check("rst_m1_start", M1_start, 0);
    check("rst_m2_start", M2_start, 0);
    check("rst_rx_init", UART_rx_initialize, 0);
    check("rst_rx_enable", UART_rx_enable, 0);
    check("rst_wdog", Wdog_error, 0);

    Resetn = 1'b1;
    step();
    check("idle_stays_grant", Grant, G_VGA);

    for (int i = 0; i < 4; i++) begin
      UART_SRAM_address    = idle_tab[i].own_addr;
      UART_SRAM_write_data = idle_tab[i].own_data;
      UART_SRAM_we_n       = idle_tab[i].own_we_n;
      VGA_SRAM_address     = idle_tab[i].vga_addr;
      #1;
      check($sformatf("idle_mux_addr[%0d]", i), SRAM_address, idle_tab[i].exp_addr);
      check($sformatf("idle_mux_data[%0d]", i), SRAM_write_data, idle_tab[i].exp_data);
      check($sformatf("idle_mux_we_n[%0d]", i), SRAM_we_n, idle_tab[i].exp_we_n);
      step();
    end
    UART_SRAM_we_n = 1'b1;
    UART_SRAM_address = '0;

    // Load sequence with three UART writes
    Start_req = 1'b1;
    step();
    Start_req = 1'b0;
    check("init_rx_init", UART_rx_initialize, 1);
    check("init_grant", Grant, G_UART);
    check("init_vga_enable", VGA_enable, 0);
    check("init_busy", Busy, 1);
    step();
    check("en_rx_enable", UART_rx_enable, 1);
    check("en_rx_init", UART_rx_initialize, 0);
    step();
    check("wait_rx_enable", UART_rx_enable, 0);
    for (int a = 1; a <= 3; a++) begin
      UART_SRAM_address    = 18'(a);
      UART_SRAM_write_data = 16'(a * 16'h0111);
      UART_SRAM_we_n       = 1'b0;
      #1;
      check($sformatf("uart_wr_addr[%0d]", a), SRAM_address, a);
      check($sformatf("uart_wr_we_n[%0d]", a), SRAM_we_n, 0);
      step();
    end
    UART_SRAM_we_n = 1'b1;
    cyc = 1;
    while (!UART_rx_initialize && cyc < 300) begin
      step();
      cyc++;
    end
    check("uart_timeout_latency", cyc, 101);
    check("timeout_grant_uart", Grant, G_UART);
    step();
    check("guard1_grant", Grant, G_IDLE);
    check("guard1_rx_init", UART_rx_initialize, 0);
    check("guard1_we_n", SRAM_we_n, 1);
    check("guard1_addr_hold", SRAM_address, 3);
    step();
    check("m2_grant", Grant, G_M2);
    check("m2_start", M2_start, 1);

    // M2 write then done; one guard cycle, then M1 owns the bus
    M2_SRAM_address = 18'h01234; M2_SRAM_write_data = 16'hBEEF; M2_SRAM_we_n = 1'b0;
    M1_SRAM_address = 18'h2AAAA; M1_SRAM_write_data = 16'h5555; M1_SRAM_we_n = 1'b1;
    #1;
    check("m2_mux_addr", SRAM_address, 18'h01234);
    check("m2_mux_data", SRAM_write_data, 16'hBEEF);
    check("m2_mux_we_n", SRAM_we_n, 0);
    M2_done = 1'b1;
    step();
    M2_done = 1'b0;
    check("guard2_m2_start", M2_start, 0);
    check("guard2_grant", Grant, G_IDLE);
    check("guard2_we_n", SRAM_we_n, 1);
    check("guard2_addr_hold", SRAM_address, 18'h01234);
    step();
    check("m1_grant", Grant, G_M1);
    check("m1_addr", SRAM_address, 18'h2AAAA);
    check("m1_start", M1_start, 1);

    for (int i = 0; i < 4; i++) begin
      M1_SRAM_address    = m1_tab[i].own_addr;
      M1_SRAM_write_data = m1_tab[i].own_data;
      M1_SRAM_we_n       = m1_tab[i].own_we_n;
      VGA_SRAM_address   = m1_tab[i].vga_addr;
      #1;
      check($sformatf("m1_mux_addr[%0d]", i), SRAM_address, m1_tab[i].exp_addr);
      check($sformatf("m1_mux_data[%0d]", i), SRAM_write_data, m1_tab[i].exp_data);
      check($sformatf("m1_mux_we_n[%0d]", i), SRAM_we_n, m1_tab[i].exp_we_n);
    end
    M1_SRAM_we_n = 1'b1;
    M2_SRAM_we_n = 1'b1;
    M1_done = 1'b1;
    step();
    M1_done = 1'b0;
    check("guard3_grant", Grant, G_IDLE);
    check("guard3_m1_start", M1_start, 0);
    step();
    check("display_grant", Grant, G_VGA);
    check("display_vga_enable", VGA_enable, 1);
    check("display_busy", Busy, 1);
    step();
    check("back_idle_busy", Busy, 0);

    // Watchdog expiry in M1
    start_load();
    finish_load_to_m1();
    repeat (49) step();
    check("wdog_49_error", Wdog_error, 0);
    check("wdog_49_m1_start", M1_start, 1);
    step();
    check("wdog_50_error", Wdog_error, 1);
    check("wdog_50_m1_start", M1_start, 0);
    step();
    check("wdog_guard_grant", Grant, G_IDLE);
    check("wdog_guard_error", Wdog_error, 1);
    step();
    check("wdog_idle_grant", Grant, G_VGA);
    check("wdog_idle_busy", Busy, 0);
    step();
    check("wdog_error_sticky", Wdog_error, 1);

    // Done and watchdog expiry on the same cycle: done wins
    start_load();
    check("wdog_clr_on_start", Wdog_error, 0);
    finish_load_to_m1();
    repeat (50) step();
    M1_done = 1'b1;
    #1;
    check("prio_error", Wdog_error, 0);
    check("prio_m1_start", M1_start, 1);
    step();
    M1_done = 1'b0;
    check("prio_guard_error", Wdog_error, 0);
    step();
    check("prio_display_grant", Grant, G_VGA);
    check("prio_display_vga", VGA_enable, 1);
    step();

    // No UART writes: UART_WAIT must hold
    UART_SRAM_address = '0;
    start_load();
    bad = 0;
    repeat (300) begin
      step();
      if (Grant !== G_UART || UART_rx_initialize !== 1'b0 || Busy !== 1'b1) bad++;
    end
    check("uart_wait_hold_bad_cycles", bad, 0);

    // Reset while in M1
    finish_load_to_m1();
    M1_SRAM_we_n = 1'b0;
    Resetn = 1'b0;
    #1;
    check("midrst_grant", Grant, G_VGA);
    check("midrst_vga_enable", VGA_enable, 1);
    check("midrst_we_n", SRAM_we_n, 1);
    check("midrst_m1_start", M1_start, 0);
    check("midrst_busy", Busy, 0);
    step();
    Resetn = 1'b1;
    M1_SRAM_we_n = 1'b1;
    step();
    check("post_rst_idle", Grant, G_VGA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
